// File: rtl/dw02_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package dw02_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Bits needed to count A_width-1 down to 0.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/dw02_div_abs.sv
// Conditional two's-complement negate: y = neg ? -x : x.
module dw02_div_abs #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] x,
    input  logic         neg,
    output logic [W-1:0] y
);

    assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/dw02_div_seq.sv
// Sequential radix-2 restoring divider, one quotient bit per clock,
// unsigned or two's-complement operands with START/DONE handshake.
module dw02_div_seq
    import dw02_div_pkg::*;
#(
    parameter int unsigned A_width = 8,
    parameter int unsigned B_width = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic               TC,
    input  logic [A_width-1:0] A,
    input  logic [B_width-1:0] B,
    output logic               BUSY,
    output logic               DONE,
    output logic [A_width-1:0] QUOTIENT,
    output logic [B_width-1:0] REMAINDER,
    output logic               DIVIDE_BY_0
);

    localparam int unsigned CW = cnt_width(A_width);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [B_width:0]   prem;
    logic [A_width-1:0] qreg;
    logic [B_width-1:0] bmag;
    logic [B_width-1:0] a_lo;
    logic               sa;
    logic               sb;

    logic               a_neg;
    logic               b_neg;
    logic [A_width-1:0] a_abs;
    logic [B_width-1:0] b_abs;
    logic [A_width-1:0] q_fix;
    logic [B_width-1:0] r_fix;
    logic [B_width:0]   shifted;
    logic [B_width:0]   diff;

    assign a_neg = TC & A[A_width-1];
    assign b_neg = TC & B[B_width-1];

    dw02_div_abs #(.W(A_width)) u_a_abs (.x(A), .neg(a_neg), .y(a_abs));
    dw02_div_abs #(.W(B_width)) u_b_abs (.x(B), .neg(b_neg), .y(b_abs));
    dw02_div_abs #(.W(A_width)) u_q_fix (.x(qreg), .neg(sa ^ sb), .y(q_fix));
    dw02_div_abs #(.W(B_width)) u_r_fix (.x(prem[B_width-1:0]), .neg(sa), .y(r_fix));

    // Dividend bits leave qreg at the top while quotient bits enter at the bottom.
    assign shifted = {prem[B_width-1:0], qreg[A_width-1]};
    assign diff    = shifted - {1'b0, bmag};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            prem        <= '0;
            qreg        <= '0;
            bmag        <= '0;
            a_lo        <= '0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            QUOTIENT    <= '0;
            REMAINDER   <= '0;
            DIVIDE_BY_0 <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        state       <= ST_CALC;
                        cnt         <= CW'(A_width - 1);
                        prem        <= '0;
                        qreg        <= a_abs;
                        bmag        <= b_abs;
                        a_lo        <= B_width'(A);
                        sa          <= a_neg;
                        sb          <= b_neg;
                        BUSY        <= 1'b1;
                        DIVIDE_BY_0 <= 1'b0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (diff[B_width]) begin
                        prem <= shifted;
                        qreg <= {qreg[A_width-2:0], 1'b0};
                    end else begin
                        prem <= diff;
                        qreg <= {qreg[A_width-2:0], 1'b1};
                    end
                    if (cnt == '0) begin
                        state <= ST_FIX;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_FIX: begin
                    // Divide-by-zero runs the full iteration, then overrides the result here.
                    if (bmag == '0) begin
                        QUOTIENT    <= '1;
                        REMAINDER   <= a_lo;
                        DIVIDE_BY_0 <= 1'b1;
                    end else begin
                        QUOTIENT  <= q_fix;
                        REMAINDER <= r_fix;
                    end
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                    state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dw02_div_seq.sv
// Self-checking bench for dw02_div_seq (A_width = B_width = 8).
module tb_dw02_div_seq;

    localparam int unsigned AW = 8;
    localparam int unsigned BW = 8;
    localparam int LAT = 9;

    logic          CLK = 1'b0;
    logic          RST;
    logic          START;
    logic          TC;
    logic [AW-1:0] A;
    logic [BW-1:0] B;
    logic          BUSY;
    logic          DONE;
    logic [AW-1:0] QUOTIENT;
    logic [BW-1:0] REMAINDER;
    logic          DIVIDE_BY_0;

    int checks   = 0;
    int failures = 0;

    dw02_div_seq #(.A_width(AW), .B_width(BW)) dut (
        .CLK(CLK), .RST(RST), .START(START), .TC(TC), .A(A), .B(B),
        .BUSY(BUSY), .DONE(DONE), .QUOTIENT(QUOTIENT), .REMAINDER(REMAINDER),
        .DIVIDE_BY_0(DIVIDE_BY_0)
    );

    always #5 CLK = ~CLK;

    // Reference: integer division truncating toward zero, remainder takes sign of A.
    function automatic void model(input bit tc, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r, output bit dz);
        int sa, sb, qq, rr;
        if (b == 8'd0) begin
            q = 8'hFF; r = a; dz = 1'b1;
        end else if (tc) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            qq = sa / sb;
            rr = sa % sb;
            q = qq[7:0]; r = rr[7:0]; dz = 1'b0;
        end else begin
            q = a / b; r = a % b; dz = 1'b0;
        end
    endfunction

    // Present operands and START, return 1 time unit after the capturing edge.
    task automatic launch(input bit tc, input logic [7:0] a, input logic [7:0] b, input bit hold);
        @(negedge CLK);
        TC = tc; A = a; B = b; START = 1'b1;
        @(posedge CLK);
        #1;
        if (!hold) begin
            START = 1'b0;
            A = 8'($urandom);
            B = 8'($urandom);
            TC = 1'($urandom);
        end
    endtask

    // Count edges until DONE; optionally pulse START with junk operands at edge 'glitch'.
    task automatic wait_done(input int glitch, output int lat, output int busy);
        lat  = 0;
        busy = BUSY ? 1 : 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge CLK);
            #1;
            if (BUSY) busy++;
            if (DONE) begin
                lat = i;
                break;
            end
            if (glitch > 0 && i == glitch) begin
                START = 1'b1; A = 8'($urandom); B = 8'($urandom); TC = 1'($urandom);
            end
            if (glitch > 0 && i == glitch + 1) START = 1'b0;
        end
        checks++;
        if (lat == 0) begin
            failures++;
            $display("FAIL done_timeout: got no DONE within 20 cycles, required one");
        end
    endtask

    task automatic test_reset;
        RST = 1'b1; START = 1'b0; TC = 1'b0; A = '0; B = '0;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({BUSY, DONE, QUOTIENT, REMAINDER, DIVIDE_BY_0} !== 19'd0) begin
            failures++;
            $display("FAIL reset_state: got %h required 0",
                     {BUSY, DONE, QUOTIENT, REMAINDER, DIVIDE_BY_0});
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_basic;
        int lat, busy;
        launch(1'b0, 8'd200, 8'd7, 1'b0);
        wait_done(0, lat, busy);
        checks++;
        if (lat !== LAT) begin failures++; $display("FAIL basic_latency: got %0d required %0d", lat, LAT); end
        checks++;
        if (busy !== 9) begin failures++; $display("FAIL basic_busy_cycles: got %0d required 9", busy); end
        checks++;
        if ({QUOTIENT, REMAINDER, DIVIDE_BY_0} !== {8'd28, 8'd4, 1'b0}) begin
            failures++;
            $display("FAIL basic_result: got q=%0d r=%0d dz=%b required q=28 r=4 dz=0",
                     QUOTIENT, REMAINDER, DIVIDE_BY_0);
        end
        @(posedge CLK);
        #1;
        checks++;
        if ({DONE, BUSY} !== 2'b00) begin
            failures++;
            $display("FAIL done_pulse: got done=%b busy=%b required 0 0", DONE, BUSY);
        end
    endtask

    task automatic test_signed;
        int lat, busy;
        launch(1'b1, 8'hF9, 8'h02, 1'b0);
        wait_done(0, lat, busy);
        checks++;
        if ({QUOTIENT, REMAINDER, DIVIDE_BY_0} !== {8'hFD, 8'hFF, 1'b0}) begin
            failures++;
            $display("FAIL signed_neg_a: got q=%h r=%h dz=%b required q=fd r=ff dz=0",
                     QUOTIENT, REMAINDER, DIVIDE_BY_0);
        end
        launch(1'b1, 8'h07, 8'hFE, 1'b0);
        wait_done(0, lat, busy);
        checks++;
        if ({QUOTIENT, REMAINDER, DIVIDE_BY_0} !== {8'hFD, 8'h01, 1'b0}) begin
            failures++;
            $display("FAIL signed_neg_b: got q=%h r=%h dz=%b required q=fd r=01 dz=0",
                     QUOTIENT, REMAINDER, DIVIDE_BY_0);
        end
        launch(1'b1, 8'h80, 8'hFF, 1'b0);
        wait_done(0, lat, busy);
        checks++;
        if ({QUOTIENT, REMAINDER, DIVIDE_BY_0} !== {8'h80, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL tc_overflow: got q=%h r=%h dz=%b required q=80 r=00 dz=0",
                     QUOTIENT, REMAINDER, DIVIDE_BY_0);
        end
    endtask

    task automatic test_div0;
        int lat, busy;
        for (int t = 0; t < 2; t++) begin
            launch(1'(t), 8'h55, 8'h00, 1'b0);
            wait_done(0, lat, busy);
            checks++;
            if ({lat, QUOTIENT, REMAINDER, DIVIDE_BY_0} !== {LAT, 8'hFF, 8'h55, 1'b1}) begin
                failures++;
                $display("FAIL div0_tc%0d: got lat=%0d q=%h r=%h dz=%b required lat=9 q=ff r=55 dz=1",
                         t, lat, QUOTIENT, REMAINDER, DIVIDE_BY_0);
            end
        end
        launch(1'b0, 8'd100, 8'd10, 1'b0);
        checks++;
        if (DIVIDE_BY_0 !== 1'b0) begin
            failures++;
            $display("FAIL div0_clear: got dz=%b required 0 after START", DIVIDE_BY_0);
        end
        wait_done(0, lat, busy);
        checks++;
        if ({QUOTIENT, REMAINDER, DIVIDE_BY_0} !== {8'd10, 8'd0, 1'b0}) begin
            failures++;
            $display("FAIL div0_followup: got q=%0d r=%0d dz=%b required q=10 r=0 dz=0",
                     QUOTIENT, REMAINDER, DIVIDE_BY_0);
        end
    endtask

    task automatic test_start_busy;
        int lat, busy;
        logic [7:0] eq, er;
        bit ed;
        model(1'b1, 8'hC3, 8'h05, eq, er, ed);
        launch(1'b1, 8'hC3, 8'h05, 1'b0);
        wait_done(3, lat, busy);
        checks++;
        if ({lat, QUOTIENT, REMAINDER, DIVIDE_BY_0} !== {LAT, eq, er, ed}) begin
            failures++;
            $display("FAIL start_while_busy: got lat=%0d q=%h r=%h dz=%b required lat=9 q=%h r=%h dz=%b",
                     lat, QUOTIENT, REMAINDER, DIVIDE_BY_0, eq, er, ed);
        end
    endtask

    task automatic test_back_to_back;
        int lat, busy;
        logic [7:0] eq, er;
        bit ed;
        launch(1'b0, 8'd231, 8'd12, 1'b1);
        TC = 1'b1; A = 8'hA6; B = 8'h09;
        wait_done(0, lat, busy);
        checks++;
        if ({lat, QUOTIENT, REMAINDER, DIVIDE_BY_0} !== {LAT, 8'd19, 8'd3, 1'b0}) begin
            failures++;
            $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d dz=%b required lat=9 q=19 r=3 dz=0",
                     lat, QUOTIENT, REMAINDER, DIVIDE_BY_0);
        end
        @(posedge CLK);
        #1;
        START = 1'b0;
        checks++;
        if ({BUSY, DONE} !== 2'b10) begin
            failures++;
            $display("FAIL b2b_accept: got busy=%b done=%b required 1 0", BUSY, DONE);
        end
        wait_done(0, lat, busy);
        model(1'b1, 8'hA6, 8'h09, eq, er, ed);
        checks++;
        if ({lat + 1, QUOTIENT, REMAINDER, DIVIDE_BY_0} !== {10, eq, er, ed}) begin
            failures++;
            $display("FAIL b2b_second: got gap=%0d q=%h r=%h dz=%b required gap=10 q=%h r=%h dz=%b",
                     lat + 1, QUOTIENT, REMAINDER, DIVIDE_BY_0, eq, er, ed);
        end
    endtask

    task automatic test_reset_mid;
        int lat, busy;
        bit saw;
        launch(1'b0, 8'd250, 8'd3, 1'b0);
        repeat (4) @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        checks++;
        if ({BUSY, DONE, QUOTIENT, REMAINDER, DIVIDE_BY_0} !== 19'd0) begin
            failures++;
            $display("FAIL reset_async: got %h required 0", {BUSY, DONE, QUOTIENT, REMAINDER, DIVIDE_BY_0});
        end
        @(negedge CLK);
        RST = 1'b0;
        saw = 1'b0;
        repeat (15) begin
            @(posedge CLK);
            #1;
            if (DONE || BUSY) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_done: got activity after reset, required none");
        end
        launch(1'b0, 8'd250, 8'd3, 1'b0);
        wait_done(0, lat, busy);
        checks++;
        if ({lat, QUOTIENT, REMAINDER} !== {LAT, 8'd83, 8'd1}) begin
            failures++;
            $display("FAIL reset_recover: got lat=%0d q=%0d r=%0d required lat=9 q=83 r=1",
                     lat, QUOTIENT, REMAINDER);
        end
    endtask

    task automatic test_random;
        int lat, busy;
        logic [7:0] a, b, eq, er;
        bit tc, ed;
        for (int k = 0; k < 60; k++) begin
            tc = 1'($urandom);
            a  = 8'($urandom);
            b  = (k % 9 == 0) ? 8'd0 : 8'($urandom);
            model(tc, a, b, eq, er, ed);
            launch(tc, a, b, 1'b0);
            wait_done(0, lat, busy);
            checks++;
            if ({lat, QUOTIENT, REMAINDER, DIVIDE_BY_0} !== {LAT, eq, er, ed}) begin
                failures++;
                $display("FAIL random_%0d tc=%b a=%h b=%h: got lat=%0d q=%h r=%h dz=%b required lat=9 q=%h r=%h dz=%b",
                         k, tc, a, b, lat, QUOTIENT, REMAINDER, DIVIDE_BY_0, eq, er, ed);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_div0();
        test_start_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
